weighted_rr_fifo_mux: RTL and testbench



---
 rtl/weighted_rr_fifo_mux.sv | 220 ++++++++++++++++++++++
 tb/tb_weighted_rr_fifo_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_fifo_mux.sv
// N-client weighted round-robin aggregator: per-client input FIFOs drained by a
// credit-based WRR arbiter into a shared first-word-fall-through output FIFO.
module weighted_rr_fifo_mux #(
    parameter int CLIENTS      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int OUT_DEPTH    = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic [CLIENTS-1:0]                      i_wr_valid,
    output logic [CLIENTS-1:0]                      o_wr_ready,
    input  logic [CLIENTS*DATA_WIDTH-1:0]           i_wr_data,
    input  logic [CLIENTS*WEIGHT_WIDTH-1:0]         i_weights,
    input  logic                                    i_block_arb,
    output logic                                    o_rd_valid,
    input  logic                                    i_rd_ready,
    output logic [DATA_WIDTH-1:0]                   o_rd_data,
    output logic [$clog2(CLIENTS)-1:0]              o_rd_id,
    output logic [CLIENTS*($clog2(DEPTH)+1)-1:0]    o_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int OCW = OAW + 1;
    localparam int IDW = $clog2(CLIENTS);
    localparam int OW  = IDW + DATA_WIDTH;
    localparam logic [CW-1:0]  FULL_CNT     = CW'(DEPTH);
    localparam logic [OCW-1:0] OUT_FULL_CNT = OCW'(OUT_DEPTH);
    localparam logic [IDW-1:0] LAST_ID      = IDW'(CLIENTS - 1);
    localparam logic [IDW:0]   CLIENTS_EXT  = (IDW+1)'(CLIENTS);

    logic [DATA_WIDTH-1:0]   in_mem_r [CLIENTS][DEPTH];
    logic [AW-1:0]           in_wr_ptr_r [CLIENTS];
    logic [AW-1:0]           in_rd_ptr_r [CLIENTS];
    logic [CW-1:0]           count_r [CLIENTS];
    logic [CW-1:0]           count_nxt_s [CLIENTS];
    logic [WEIGHT_WIDTH-1:0] weight_s [CLIENTS];
    logic [CLIENTS-1:0]      wr_ready_r;
    logic [CLIENTS-1:0]      push_s;
    logic [CLIENTS-1:0]      pop_s;
    logic [CLIENTS-1:0]      eligible_s;

    logic [IDW-1:0]          ptr_r;
    logic [WEIGHT_WIDTH-1:0] credit_r;
    logic [IDW-1:0]          win_s;
    logic [IDW:0]            idx_s;
    logic                    found_s;
    logic                    grant_s;
    logic [WEIGHT_WIDTH-1:0] rem_s;
    logic [WEIGHT_WIDTH-1:0] credit_nxt_s;

    logic [OW-1:0]           out_mem_r [OUT_DEPTH];
    logic [OAW-1:0]          out_wr_ptr_r;
    logic [OAW-1:0]          out_rd_ptr_r;
    logic [OCW-1:0]          out_count_r;
    logic [OCW-1:0]          out_count_nxt_s;
    logic                    rd_valid_r;
    logic                    out_full_s;
    logic                    out_pop_s;

    // Weight unpacking and eligibility from registered occupancy
    always_comb begin
        for (int k = 0; k < CLIENTS; k++) begin
            weight_s[k]   = i_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            eligible_s[k] = (count_r[k] != '0) && (weight_s[k] != '0);
        end
    end

    // Rotating first-eligible search starting at the pointer
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            idx_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (idx_s >= CLIENTS_EXT) begin
                idx_s = idx_s - CLIENTS_EXT;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && eligible_s[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant qualification and the winner's remaining quantum
    always_comb begin
        out_full_s = (out_count_r == OUT_FULL_CNT);
        grant_s    = found_s && !i_block_arb && !out_full_s;
        if ((win_s == ptr_r) && (credit_r != '0)) begin
            rem_s = credit_r;
        end else begin
            rem_s = weight_s[win_s];
        end
        credit_nxt_s = rem_s - WEIGHT_WIDTH'(1'b1);
    end

    // Per-client push/pop qualifiers and next occupancy
    always_comb begin
        for (int k = 0; k < CLIENTS; k++) begin
            push_s[k] = i_wr_valid[k] && wr_ready_r[k];
            pop_s[k]  = grant_s && (win_s == IDW'(k));
            if (push_s[k] && !pop_s[k]) begin
                count_nxt_s[k] = count_r[k] + CW'(1'b1);
            end else if (pop_s[k] && !push_s[k]) begin
                count_nxt_s[k] = count_r[k] - CW'(1'b1);
            end else begin
                count_nxt_s[k] = count_r[k];
            end
        end
    end

    // Input FIFO pointers, occupancy and registered ready flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < CLIENTS; k++) begin
                in_wr_ptr_r[k] <= '0;
                in_rd_ptr_r[k] <= '0;
                count_r[k]     <= '0;
                wr_ready_r[k]  <= 1'b1;
            end
        end else begin
            for (int k = 0; k < CLIENTS; k++) begin
                if (push_s[k]) begin
                    in_wr_ptr_r[k] <= in_wr_ptr_r[k] + AW'(1'b1);
                end
                if (pop_s[k]) begin
                    in_rd_ptr_r[k] <= in_rd_ptr_r[k] + AW'(1'b1);
                end
                count_r[k]    <= count_nxt_s[k];
                wr_ready_r[k] <= (count_nxt_s[k] != FULL_CNT);
            end
        end
    end

    // Input FIFO storage; stale contents are unreachable after reset
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < CLIENTS; k++) begin
            if (push_s[k]) begin
                in_mem_r[k][in_wr_ptr_r[k]] <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter pointer and credit: keep the pointer while quantum remains
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r    <= '0;
            credit_r <= '0;
        end else if (grant_s) begin
            if (credit_nxt_s == '0) begin
                ptr_r    <= (win_s == LAST_ID) ? '0 : win_s + IDW'(1'b1);
                credit_r <= '0;
            end else begin
                ptr_r    <= win_s;
                credit_r <= credit_nxt_s;
            end
        end
    end

    // Output FIFO next occupancy
    always_comb begin
        out_pop_s = rd_valid_r && i_rd_ready;
        if (grant_s && !out_pop_s) begin
            out_count_nxt_s = out_count_r + OCW'(1'b1);
        end else if (out_pop_s && !grant_s) begin
            out_count_nxt_s = out_count_r - OCW'(1'b1);
        end else begin
            out_count_nxt_s = out_count_r;
        end
    end

    // Output FIFO pointers, occupancy and registered valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_wr_ptr_r <= '0;
            out_rd_ptr_r <= '0;
            out_count_r  <= '0;
            rd_valid_r   <= 1'b0;
        end else begin
            if (grant_s) begin
                out_wr_ptr_r <= out_wr_ptr_r + OAW'(1'b1);
            end
            if (out_pop_s) begin
                out_rd_ptr_r <= out_rd_ptr_r + OAW'(1'b1);
            end
            out_count_r <= out_count_nxt_s;
            rd_valid_r  <= (out_count_nxt_s != '0);
        end
    end

    // Output storage is cleared so the head word reads zero out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < OUT_DEPTH; j++) begin
                out_mem_r[j] <= '0;
            end
        end else if (grant_s) begin
            out_mem_r[out_wr_ptr_r] <= {win_s, in_mem_r[win_s][in_rd_ptr_r[win_s]]};
        end
    end

    // Occupancy bus packing
    always_comb begin
        for (int k = 0; k < CLIENTS; k++) begin
            o_count[k*CW +: CW] = count_r[k];
        end
    end

    assign o_wr_ready           = wr_ready_r;
    assign o_rd_valid           = rd_valid_r;
    assign {o_rd_id, o_rd_data} = out_mem_r[out_rd_ptr_r];

endmodule

// File: tb/tb_weighted_rr_fifo_mux.sv
// Scoreboard bench for weighted_rr_fifo_mux: a queue-level reference model predicts
// every output word; a negedge monitor compares the DUT head word and occupancies.
module tb_weighted_rr_fifo_mux;
    localparam int N = 4, DW = 8, DEPTH = 8, OUT_DEPTH = 4, WW = 4, CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    wr_valid = '0;
    logic [N-1:0]    wr_ready;
    logic [N*DW-1:0] wr_data = '0;
    logic [N*WW-1:0] weights = 16'h4321;
    logic            block_arb = 1'b0;
    logic            rd_valid;
    logic            rd_ready = 1'b1;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_id;
    logic [N*CW-1:0] count;

    weighted_rr_fifo_mux #(.CLIENTS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                           .OUT_DEPTH(OUT_DEPTH), .WEIGHT_WIDTH(WW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_data(wr_data), .i_weights(weights), .i_block_arb(block_arb),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_rd_id(rd_id), .o_count(count));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state: per-client queues, round-robin position, quantum left
    logic [DW-1:0] mq [N][$];
    logic [9:0]    exp_q [$];
    int            ptr_m = 0;
    int            credit_m = 0;
    int            out_cnt_m = 0;
    int            obs_q [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wt(input int k);
        return int'(weights[k*WW +: WW]);
    endfunction

    function automatic int busy();
        int b = (out_cnt_m != 0) ? 1 : 0;
        for (int k = 0; k < N; k++) if (mq[k].size() != 0) b = 1;
        return b;
    endfunction

    function automatic int count_of(input int k);
        return int'(count[k*CW +: CW]);
    endfunction

    // one clock edge of the reference: serve, then pop consumer side, then accept pushes
    task automatic model_step();
        int  w = -1;
        int  rem;
        bit  gnt = 1'b0;
        bit  acc [N];
        logic [9:0] ent = '0;
        for (int k = 0; k < N; k++) acc[k] = wr_valid[k] && (mq[k].size() < DEPTH);
        for (int i = 0; i < N; i++) begin
            int c = (ptr_m + i) % N;
            if (w < 0 && mq[c].size() > 0 && wt(c) != 0) w = c;
        end
        if (w >= 0 && !block_arb && out_cnt_m < OUT_DEPTH) begin
            rem = (w == ptr_m && credit_m != 0) ? credit_m : wt(w);
            rem = rem - 1;
            if (rem == 0) begin
                ptr_m = (w + 1) % N;
                credit_m = 0;
            end else begin
                ptr_m = w;
                credit_m = rem;
            end
            ent = {2'(w), mq[w].pop_front()};
            gnt = 1'b1;
        end
        if (out_cnt_m > 0 && rd_ready) out_cnt_m--;
        if (gnt) begin
            out_cnt_m++;
            exp_q.push_back(ent);
        end
        for (int k = 0; k < N; k++) if (acc[k]) mq[k].push_back(wr_data[k*DW +: DW]);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < N; k++) mq[k].delete();
                exp_q.delete();
                ptr_m = 0;
                credit_m = 0;
                out_cnt_m = 0;
            end else begin
                model_step();
            end
        end
    end

    // monitor: compare DUT against model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rd_valid", int'(rd_valid), int'(out_cnt_m != 0));
                if (rd_valid) begin
                    chk("exp_avail", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("rd_data", int'(rd_data), int'(exp_q[0][7:0]));
                        chk("rd_id", int'(rd_id), int'(exp_q[0][9:8]));
                        if (rd_ready) begin
                            obs_q.push_back(int'(rd_id));
                            void'(exp_q.pop_front());
                        end
                    end
                end
                for (int k = 0; k < N; k++) begin
                    chk("count", count_of(k), mq[k].size());
                    chk("wr_ready", int'(wr_ready[k]), int'(mq[k].size() != DEPTH));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 15);
    endtask

    task automatic apply_reset();
        wr_valid = '0;
        block_arb = 1'b0;
        rst_n = 1'b0;
        #2;
        reset_checks("rst");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [N-1:0] mask, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            wr_valid = mask;
            wr_data = {$urandom};
            tick();
        end
        wr_valid = '0;
    endtask

    task automatic drain();
        int n = 0;
        wr_valid = '0;
        block_arb = 1'b0;
        rd_ready = 1'b1;
        while (busy() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("drain_done", busy(), 0);
        tick();
        tick();
    endtask

    function automatic int ids_equal(input int id);
        int c = 0;
        foreach (obs_q[i]) if (obs_q[i] == id) c++;
        return c;
    endfunction

    initial begin
        int pat [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        int blk [10] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 0};
        int sum;
        #2 rst_n = 1'b0;
        #2;
        reset_checks("init");
        chk("init_rd_data", int'(rd_data), 0);
        chk("init_rd_id", int'(rd_id), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // weighted sequence from a preloaded, all-client start
        weights = 16'h4321;
        block_arb = 1'b1;
        load(4'hF, 8);
        obs_q.delete();
        drain();
        chk("wrr_total", obs_q.size(), 32);
        if (obs_q.size() >= 20) for (int i = 0; i < 20; i++) chk("wrr_seq", obs_q[i], pat[i % 10]);

        // weight-0 client fills and is never served
        weights = 16'h3021;
        obs_q.delete();
        load(4'b0100, 9);
        repeat (5) tick();
        chk("w0_ready", int'(wr_ready[2]), 0);
        chk("w0_count", count_of(2), 8);
        chk("w0_no_grant", ids_equal(2), 0);
        weights = 16'h3321;
        drain();
        chk("w0_drained", ids_equal(2), 8);

        // output backpressure: exactly OUT_DEPTH grants then hold
        rd_ready = 1'b0;
        block_arb = 1'b1;
        weights = 16'h2222;
        load(4'hF, 4);
        block_arb = 1'b0;
        repeat (10) tick();
        sum = 0;
        for (int k = 0; k < N; k++) sum += count_of(k);
        chk("bp_taken", sum, 16 - OUT_DEPTH);
        chk("bp_valid", int'(rd_valid), 1);
        repeat (5) tick();
        sum = 0;
        for (int k = 0; k < N; k++) sum += count_of(k);
        chk("bp_hold", sum, 16 - OUT_DEPTH);
        obs_q.delete();
        drain();
        chk("bp_total", obs_q.size(), 16);

        // block mid-quantum with client 3 holding two credits
        apply_reset();
        weights = 16'h4111;
        block_arb = 1'b1;
        load(4'b1000, 8);
        obs_q.delete();
        block_arb = 1'b0;
        tick();
        tick();
        block_arb = 1'b1;
        load(4'b0001, 2);
        repeat (3) tick();
        chk("blk_count3", count_of(3), 6);
        chk("blk_count0", count_of(0), 2);
        drain();
        chk("blk_total", obs_q.size(), 10);
        if (obs_q.size() >= 10) for (int i = 0; i < 10; i++) chk("blk_seq", obs_q[i], blk[i]);

        // single active client across a quantum boundary
        weights = 16'h2131;
        obs_q.delete();
        load(4'b0010, 5);
        drain();
        chk("solo_total", obs_q.size(), 5);
        chk("solo_ids", ids_equal(1), 5);

        // randomized traffic, with an asynchronous reset partway through
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) weights = 16'($urandom);
            wr_valid = 4'($urandom);
            wr_data = {$urandom};
            block_arb = ($urandom_range(0, 7) == 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            if (c == 800) begin
                wr_valid = '0;
                rst_n = 1'b0;
                #2;
                reset_checks("mid");
                tick();
                rst_n = 1'b1;
                weights = 16'h2222;
                block_arb = 1'b1;
                load(4'hF, 2);
                obs_q.delete();
                drain();
                chk("mid_total", obs_q.size(), 8);
                if (obs_q.size() > 0) chk("mid_first", obs_q[0], 0);
            end
            tick();
        end
        weights = 16'h3457;
        drain();
        chk("end_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
